// File: rtl/pc_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit_if
// Purpose : bundles the fetch-stage bus between the PC fetch unit and its
//           surroundings (instruction memory, PC adder, hazard unit, branch
//           and jump resolution, IF/ID consumer).
// Modports:
//   slave  - the fetch unit itself: takes the request/data inputs and drives
//            PCResult, the IF/ID register outputs, MisalignErr and FetchState.
//   master - the environment: drives the requests and data, observes outputs.
// Signals :
//   Instruction  [31:0]  imem read data for the current PCResult
//   PCAddResult  [31:0]  PCResult + 4 from the PC adder
//   Stall                hazard-unit hold request
//   BranchTaken          taken-branch redirect request
//   BranchTarget [31:0]  branch target address
//   Jump                 jump redirect request
//   JumpTarget   [31:0]  jump target address
//   PCResult     [31:0]  registered fetch address
//   IFID_Instruction [31:0], IFID_PCPlus4 [31:0], IFID_Valid  IF/ID register
//   MisalignErr          sticky misaligned-redirect flag
//   FetchState   [1:0]   BOOT=00, RUN=01, HOLD=10
// ---------------------------------------------------------------------------
interface pc_fetch_unit_if;
  logic [31:0] Instruction;
  logic [31:0] PCAddResult;
  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        Jump;
  logic [31:0] JumpTarget;

  logic [31:0] PCResult;
  logic [31:0] IFID_Instruction;
  logic [31:0] IFID_PCPlus4;
  logic        IFID_Valid;
  logic        MisalignErr;
  logic [1:0]  FetchState;

  modport slave (
    input  Instruction, PCAddResult, Stall, BranchTaken, BranchTarget,
           Jump, JumpTarget,
    output PCResult, IFID_Instruction, IFID_PCPlus4, IFID_Valid,
           MisalignErr, FetchState
  );

  modport master (
    output Instruction, PCAddResult, Stall, BranchTaken, BranchTarget,
           Jump, JumpTarget,
    input  PCResult, IFID_Instruction, IFID_PCPlus4, IFID_Valid,
           MisalignErr, FetchState
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
// Purpose : instruction-fetch stage. Holds the program counter and the IF/ID
//           pipeline register, applies branch/jump redirects and hazard
//           stalls, and flags redirects to non-word-aligned targets.
// Ports   :
//   Clk    - sole clock, rising edge
//   Reset  - asynchronous, active-low reset
//   bus    - pc_fetch_unit_if.slave (see the interface file for signals)
// Parameter:
//   RESET_PC - PC value loaded while Reset is low
//
// State | meaning
// BOOT  | first edge after reset: PC held, IF/ID bubbled, requests ignored
// RUN   | normal fetch; redirects and stalls evaluated every edge
// HOLD  | stalled; PC and IF/ID frozen until Stall drops or a redirect
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic             Clk,
  input logic             Reset,
  pc_fetch_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10
  } fetch_state_t;

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_ifid_instr;
  logic [31:0]  r_ifid_pc4;
  logic         r_ifid_valid;
  logic         r_misalign;

  // Branch has priority over jump; only the selected target is inspected
  // for misalignment, so a bad JumpTarget under a taken branch is harmless.
  logic         w_redirect;
  logic [31:0]  w_target;

  assign w_redirect = bus.BranchTaken | bus.Jump;
  assign w_target   = bus.BranchTaken ? bus.BranchTarget : bus.JumpTarget;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state      <= ST_BOOT;
      r_pc         <= RESET_PC;
      r_ifid_instr <= 32'h0;
      r_ifid_pc4   <= 32'h0;
      r_ifid_valid <= 1'b0;
      r_misalign   <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          r_ifid_instr <= 32'h0;
          r_ifid_pc4   <= 32'h0;
          r_ifid_valid <= 1'b0;
          r_state      <= ST_RUN;
        end
        ST_RUN, ST_HOLD: begin
          if (w_redirect) begin
            r_pc         <= {w_target[31:2], 2'b00};
            r_ifid_instr <= 32'h0;
            r_ifid_pc4   <= 32'h0;
            r_ifid_valid <= 1'b0;
            if (w_target[1:0] != 2'b00) begin
              r_misalign <= 1'b1;
            end
            r_state      <= ST_RUN;
          end else if (bus.Stall) begin
            r_state      <= ST_HOLD;
          end else begin
            // PC adder output taken as-is; wrap past 0xFFFFFFFC is legal.
            r_pc         <= bus.PCAddResult;
            r_ifid_instr <= bus.Instruction;
            r_ifid_pc4   <= bus.PCAddResult;
            r_ifid_valid <= 1'b1;
            r_state      <= ST_RUN;
          end
        end
        default: begin
          r_state <= ST_BOOT;
        end
      endcase
    end
  end

  assign bus.PCResult         = r_pc;
  assign bus.IFID_Instruction = r_ifid_instr;
  assign bus.IFID_PCPlus4     = r_ifid_pc4;
  assign bus.IFID_Valid       = r_ifid_valid;
  assign bus.MisalignErr      = r_misalign;
  assign bus.FetchState       = r_state;

endmodule
